// File: rtl/sipo_8_asyncrst.sv
// Serial-in / parallel-out byte receiver with optional even-parity check.
// Completed bytes are presented on D with a single-cycle d_valid strobe.
module sipo_8_asyncrst #(
    parameter bit PARITY_EN = 1'b1,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       bit_en,
    input  logic       s_bit,
    output logic [7:0] D,
    output logic       d_valid,
    output logic       par_err,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;

    state_t     state_reg;
    logic [7:0] shift_reg;
    logic [2:0] cnt_reg;
    logic [7:0] shift_next;

    // Shift register contents after accepting s_bit; the first bit of a
    // frame migrates to D[7] (MSB_FIRST) or to D[0] by the eighth bit.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_shift
            if (MSB_FIRST) begin : g_msb
                if (gi == 0) begin : g_in
                    assign shift_next[gi] = s_bit;
                end else begin : g_mv
                    assign shift_next[gi] = shift_reg[gi-1];
                end
            end else begin : g_lsb
                if (gi == 7) begin : g_in
                    assign shift_next[gi] = s_bit;
                end else begin : g_mv
                    assign shift_next[gi] = shift_reg[gi+1];
                end
            end
        end
    endgenerate

    assign busy = (state_reg != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            shift_reg <= 8'h00;
            cnt_reg   <= 3'd0;
            D         <= 8'h00;
            d_valid   <= 1'b0;
            par_err   <= 1'b0;
        end else begin
            d_valid <= 1'b0;
            par_err <= 1'b0;
            // start wins over any bit presented in the same cycle
            if (start) begin
                state_reg <= DATA;
                cnt_reg   <= 3'd0;
                shift_reg <= 8'h00;
            end else begin
                case (state_reg)
                    IDLE: ;
                    DATA: begin
                        if (bit_en) begin
                            shift_reg <= shift_next;
                            if (cnt_reg == 3'd7) begin
                                cnt_reg <= 3'd0;
                                if (PARITY_EN) begin
                                    state_reg <= PARITY;
                                end else begin
                                    D         <= shift_next;
                                    d_valid   <= 1'b1;
                                    state_reg <= IDLE;
                                end
                            end else begin
                                cnt_reg <= cnt_reg + 3'd1;
                            end
                        end
                    end
                    PARITY: begin
                        if (bit_en) begin
                            if ((^shift_reg ^ s_bit) == 1'b0) begin
                                D       <= shift_reg;
                                d_valid <= 1'b1;
                            end else begin
                                par_err <= 1'b1;
                            end
                            state_reg <= IDLE;
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sipo_8_asyncrst.sv
// Directed bench for sipo_8_asyncrst: default build (A) and an
// LSB-first, no-parity build (B), checked through per-instance scoreboards.
module tb_sipo_8_asyncrst;

    typedef struct {
        bit         err;
        logic [7:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic       start_a = 1'b0, bit_en_a = 1'b0, s_bit_a = 1'b0;
    logic [7:0] d_a;
    logic       dv_a, pe_a, busy_a;

    logic       start_b = 1'b0, bit_en_b = 1'b0, s_bit_b = 1'b0;
    logic [7:0] d_b;
    logic       dv_b, pe_b, busy_b;

    int total = 0;
    int bad   = 0;

    exp_t exp_a[$];
    exp_t exp_b[$];
    exp_t ea, eb;

    always #5 clk = ~clk;

    sipo_8_asyncrst dut_a (
        .clk(clk), .rst(rst), .start(start_a), .bit_en(bit_en_a), .s_bit(s_bit_a),
        .D(d_a), .d_valid(dv_a), .par_err(pe_a), .busy(busy_a)
    );

    sipo_8_asyncrst #(.PARITY_EN(1'b0), .MSB_FIRST(1'b0)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .bit_en(bit_en_b), .s_bit(s_bit_b),
        .D(d_b), .d_valid(dv_b), .par_err(pe_b), .busy(busy_b)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Inputs change on the falling edge so the DUT samples them cleanly.
    task automatic drive(input bit sel, input logic st, input logic en, input logic b);
        @(negedge clk);
        if (sel) begin
            start_b = st; bit_en_b = en; s_bit_b = b;
        end else begin
            start_a = st; bit_en_a = en; s_bit_a = b;
        end
    endtask

    // Sends the first n bits of v in order v[7], v[6], ... with gap idle cycles after each.
    task automatic send_bits(input bit sel, input logic [7:0] v, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            drive(sel, 1'b0, 1'b1, v[7-i]);
            repeat (gap) drive(sel, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic push(input bit sel, input bit err, input logic [7:0] data);
        exp_t e;
        e.err  = err;
        e.data = data;
        if (sel) exp_b.push_back(e);
        else     exp_a.push_back(e);
    endtask

    // Scoreboard monitors: every output strobe must match the next expectation.
    always @(negedge clk) begin
        if (dv_a === 1'b1 || pe_a === 1'b1) begin
            if (exp_a.size() == 0) begin
                total++; bad++;
                $display("FAIL a_unexpected: got dv=%b pe=%b D=%h want no strobe", dv_a, pe_a, d_a);
            end else begin
                ea = exp_a.pop_front();
                chk("a_strobe", {6'b0, pe_a, dv_a}, ea.err ? 8'd2 : 8'd1);
                chk("a_data", d_a, ea.data);
            end
        end
    end

    always @(negedge clk) begin
        if (dv_b === 1'b1 || pe_b === 1'b1) begin
            if (exp_b.size() == 0) begin
                total++; bad++;
                $display("FAIL b_unexpected: got dv=%b pe=%b D=%h want no strobe", dv_b, pe_b, d_b);
            end else begin
                eb = exp_b.pop_front();
                chk("b_strobe", {6'b0, pe_b, dv_b}, eb.err ? 8'd2 : 8'd1);
                chk("b_data", d_b, eb.data);
            end
        end
    end

    initial begin
        // Asynchronous reset between clock edges, checked before any edge.
        #3 rst = 1'b1;
        #1;
        chk("rst_async_D", d_a, 8'h00);
        chk("rst_async_flags", {5'b0, dv_a, pe_a, busy_a}, 8'h00);
        chk("rst_async_b", {d_b[7:0]}, 8'h00);
        // Activity while reset is held must not move anything.
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        chk("rst_hold_D", d_a, 8'h00);
        chk("rst_hold_flags", {5'b0, dv_a, pe_a, busy_a}, 8'h00);
        @(negedge clk);
        rst = 1'b0; start_a = 1'b0; bit_en_a = 1'b0; s_bit_a = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);

        // Default frame 0xAA, parity 0, continuous bits.
        push(1'b0, 1'b0, 8'hAA);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        send_bits(1'b0, 8'hAA, 8, 0);
        chk("aa_busy_parity", {7'b0, busy_a}, 8'h01);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("aa_dvalid_latency", {7'b0, dv_a}, 8'h01);
        chk("aa_D", d_a, 8'hAA);
        chk("aa_busy_low", {7'b0, busy_a}, 8'h00);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("aa_dvalid_one_cycle", {7'b0, dv_a}, 8'h00);

        // 0xFF with parity 1 is a parity error; D keeps 0xAA.
        push(1'b0, 1'b1, 8'hAA);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        send_bits(1'b0, 8'hFF, 8, 0);
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("ff_perr_flags", {6'b0, pe_a, dv_a}, 8'h02);
        chk("ff_D_held", d_a, 8'hAA);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("ff_perr_one_cycle", {7'b0, pe_a}, 8'h00);

        // Aborted frame, then 0x0F with bit_en on every third cycle.
        push(1'b0, 1'b0, 8'h0F);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        send_bits(1'b0, 8'hD0, 4, 2);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        send_bits(1'b0, 8'h0F, 8, 2);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("gap_dvalid", {7'b0, dv_a}, 8'h01);
        chk("gap_D", d_a, 8'h0F);

        // start together with bit_en mid-frame: that bit is discarded.
        push(1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        send_bits(1'b0, 8'hE0, 3, 0);
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        send_bits(1'b0, 8'h00, 8, 0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("prio_D", d_a, 8'h00);
        chk("prio_dvalid", {7'b0, dv_a}, 8'h01);

        // Reset mid-frame, then bits without start are ignored.
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        send_bits(1'b0, 8'hF8, 5, 0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("mid_busy", {7'b0, busy_a}, 8'h01);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_busy", {7'b0, busy_a}, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        send_bits(1'b0, 8'hE0, 3, 0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("mid_after_D", d_a, 8'h00);
        chk("mid_after_busy", {7'b0, busy_a}, 8'h00);

        // LSB-first, no parity: 1,0,1,0,1,0,1,0 -> 0x55.
        push(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        send_bits(1'b1, 8'hAA, 8, 0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        chk("b55_dvalid_latency", {7'b0, dv_b}, 8'h01);
        chk("b55_D", d_b, 8'h55);
        chk("b55_busy_low", {7'b0, busy_b}, 8'h00);

        // 1,1,0,0,0,0,0,0 LSB-first -> 0x03.
        push(1'b1, 1'b0, 8'h03);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        send_bits(1'b1, 8'hC0, 8, 1);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        chk("b03_D", d_b, 8'h03);

        repeat (4) drive(1'b1, 1'b0, 1'b0, 1'b0);
        chk("a_queue_drained", 8'(exp_a.size()), 8'h00);
        chk("b_queue_drained", 8'(exp_b.size()), 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
